// File: rtl/uart_word_collect_pkg.sv
// Shared types and sizes for the UART byte-to-word collector.
package uart_pkg;
    localparam int BYTES_PER_WORD = 8;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        FULL = 2'd3
    } state_t;
endpackage

// File: rtl/uart_word_collect_if.sv
// FIFO read side and word handshake of the collector; master is the collector.
interface uart_word_collect_if
    import uart_pkg::*;
();
    logic              rx_empty;
    logic [BYTE_W-1:0] rx_data;
    logic              rd;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ack;
    logic              timeout;

    modport master (
        input  rx_empty, rx_data, word_ack,
        output rd, word_out, word_valid, timeout
    );

    modport slave (
        output rx_empty, rx_data, word_ack,
        input  rd, word_out, word_valid, timeout
    );
endinterface

// File: rtl/uart_word_collect_idle_timer.sv
// Counts idle cycles of a partial word; expired is high on the final counted cycle.
module uart_idle_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] count;

    assign expired = count_en && (count == TMR_W'(TIMEOUT_CYCLES - 1));

    // Self-clearing on expiry so the next partial word starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/uart_word_collect.sv
// Reads bytes from a UART RX FIFO and assembles little-endian 64-bit words.
// Define UART_WORD_COLLECT_TIMEOUT_EN to discard partial words after TIMEOUT_CYCLES idle cycles.
module uart_word_collect
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic                 clk,
    input logic                 rst_n,
    uart_word_collect_if.master bus
);
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] word_q;
    logic              word_valid_q;
    logic              expired;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef UART_WORD_COLLECT_TIMEOUT_EN
    logic timeout_q;

    uart_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == RD),
        .count_en ((state == IDLE) && (cnt != '0)),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= expired;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign expired     = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.rd         = (state == RD);
    assign bus.word_out   = word_q;
    assign bus.word_valid = word_valid_q;

    // A pending timeout takes priority over a newly available byte in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (expired) begin
                        cnt <= '0;
                    end else if (!bus.rx_empty) begin
                        state <= RD;
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    word_q[{cnt, 3'b000} +: BYTE_W] <= bus.rx_data;
                    if (cnt == CNT_W'(BYTES_PER_WORD - 1)) begin
                        state        <= FULL;
                        word_valid_q <= 1'b1;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= IDLE;
                    end
                end
                FULL: begin
                    if (bus.word_ack) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        word_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_word_collect.sv
// Scenario bench for uart_word_collect with a queue-backed RX FIFO model and word scoreboard.
module tb_uart_word_collect;
    import uart_pkg::*;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_word_collect_if bus ();

    uart_word_collect #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]  fifo_q[$];
    logic [63:0] exp_q[$];
    int cyc = 0;
    int rd_cnt = 0;
    int to_cnt = 0;
    int first_cyc = 0;
    bit arm_first = 0;
    int n_chk = 0;
    int n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: a read strobe seen in a cycle presents the byte for the following cycle.
    always @(negedge clk) begin
        if (bus.rd === 1'b1) begin
            rd_cnt++;
            if (fifo_q.size() > 0) bus.rx_data = fifo_q.pop_front();
        end
        if (bus.timeout === 1'b1) to_cnt++;
        bus.rx_empty = (fifo_q.size() == 0);
        if (arm_first && !bus.rx_empty) begin
            first_cyc = cyc;
            arm_first = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_bytes(input logic [7:0] first, input int n);
        logic [7:0] b;
        b = first;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(b);
            b = b + 8'd1;
        end
    endtask

    task automatic wait_word(input string name);
        logic [63:0] exp;
        for (int i = 0; i < 300 && bus.word_valid !== 1'b1; i++) tick();
        n_chk++;
        if (bus.word_valid !== 1'b1) $display("FAIL %s_valid: word_valid=%b, required 1 within 300 cycles", name, bus.word_valid);
        else n_pass++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
        n_chk++;
        if (bus.word_out !== exp) $display("FAIL %s_word: got %h, expected %h", name, bus.word_out, exp);
        else n_pass++;
    endtask

    task automatic do_ack(input string name);
        bus.word_ack = 1'b1;
        tick();
        bus.word_ack = 1'b0;
        n_chk++;
        if (bus.word_valid !== 1'b0) $display("FAIL %s_ack: word_valid=%b after ack, required 0", name, bus.word_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.word_ack = 1'b0;
        repeat (3) tick();
        n_chk++; if (bus.rd !== 1'b0) $display("FAIL reset_rd: got %b, expected 0", bus.rd); else n_pass++;
        n_chk++; if (bus.word_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", bus.word_valid); else n_pass++;
        n_chk++; if (bus.timeout !== 1'b0) $display("FAIL reset_timeout: got %b, expected 0", bus.timeout); else n_pass++;
        n_chk++; if (bus.word_out !== 64'h0) $display("FAIL reset_word: got %h, expected 0", bus.word_out); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        rd_cnt = 0;
        arm_first = 1;
        push_bytes(8'h01, 8);
        exp_q.push_back(64'h0807060504030201);
        wait_word("b2b");
        n_chk++;
        if (cyc - first_cyc !== 24) $display("FAIL b2b_latency: got %0d cycles, expected 24", cyc - first_cyc);
        else n_pass++;
        n_chk++;
        if (rd_cnt !== 8) $display("FAIL b2b_rd_count: got %0d, expected 8", rd_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [63:0] held;
        bit rd_seen, changed, dropped;
        rd_seen = 0; changed = 0; dropped = 0;
        held = bus.word_out;
        push_bytes(8'h21, 8);
        exp_q.push_back(64'h2827262524232221);
        repeat (10) begin
            tick();
            if (bus.rd !== 1'b0) rd_seen = 1;
            if (bus.word_out !== held) changed = 1;
            if (bus.word_valid !== 1'b1) dropped = 1;
        end
        n_chk++; if (rd_seen) $display("FAIL bp_rd: rd=1 seen while full, expected 0"); else n_pass++;
        n_chk++; if (changed) $display("FAIL bp_stable: word_out=%h, expected held %h", bus.word_out, held); else n_pass++;
        n_chk++; if (dropped) $display("FAIL bp_valid: word_valid dropped to 0, expected 1"); else n_pass++;
        do_ack("bp");
        tick();
        n_chk++;
        if (bus.rd !== 1'b1) $display("FAIL bp_next_rd: rd=%b two cycles after ack, expected 1", bus.rd);
        else n_pass++;
        wait_word("bp2");
        do_ack("bp2");
    endtask

    task automatic test_reset_midword();
        rd_cnt = 0;
        push_bytes(8'hAA, 2);
        for (int i = 0; i < 50 && rd_cnt < 2; i++) tick();
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        n_chk++; if (bus.rd !== 1'b0) $display("FAIL rst_mid_rd: got %b, expected 0", bus.rd); else n_pass++;
        n_chk++; if (bus.word_out !== 64'h0) $display("FAIL rst_mid_word: got %h, expected 0", bus.word_out); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_chk++; if (bus.rd !== 1'b0) $display("FAIL rst_after_rd: got %b, expected 0", bus.rd); else n_pass++;
        push_bytes(8'h10, 8);
        exp_q.push_back(64'h1716151413121110);
        wait_word("rst_mid");
        do_ack("rst_mid");
    endtask

    task automatic test_ack_ignored();
        bit glitch;
        glitch = 0;
        rd_cnt = 0;
        bus.word_ack = 1'b1;
        push_bytes(8'h51, 3);
        repeat (15) begin
            tick();
            if (bus.word_valid !== 1'b0) glitch = 1;
        end
        bus.word_ack = 1'b0;
        n_chk++; if (glitch) $display("FAIL ack_ign_valid: word_valid went high, expected 0"); else n_pass++;
        n_chk++; if (rd_cnt !== 3) $display("FAIL ack_ign_rd: got %0d reads, expected 3", rd_cnt); else n_pass++;
        push_bytes(8'h54, 5);
        exp_q.push_back(64'h5857565554535251);
        wait_word("ack_ign");
        do_ack("ack_ign");
    endtask

    task automatic test_timeout();
        rd_cnt = 0;
        to_cnt = 0;
        push_bytes(8'h31, 3);
        repeat (40) tick();
`ifdef UART_WORD_COLLECT_TIMEOUT_EN
        n_chk++;
        if (to_cnt !== 1) $display("FAIL timeout_pulse: got %0d timeout cycles, expected 1", to_cnt);
        else n_pass++;
        push_bytes(8'h40, 8);
        exp_q.push_back(64'h4746454443424140);
`else
        n_chk++;
        if (to_cnt !== 0) $display("FAIL timeout_none: got %0d timeout cycles, expected 0", to_cnt);
        else n_pass++;
        push_bytes(8'h34, 5);
        exp_q.push_back(64'h3837363534333231);
`endif
        wait_word("timeout");
        do_ack("timeout");
    endtask

    initial begin
        bus.word_ack = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_reset_midword();
        test_ack_ignored();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
